// File: rtl/fft_buf_pkg.sv
// Shared definitions for the FFT output buffering: data width, triple index
// constants, serializer FSM encoding and the complex-sample type.
package fft_buf_pkg;

  localparam int DATA_W = 32;

  localparam logic [1:0] IDX_A = 2'd0;
  localparam logic [1:0] IDX_B = 2'd1;
  localparam logic [1:0] IDX_C = 2'd2;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] re;
    logic [DATA_W-1:0] img;
  } cplx_t;

endpackage

// File: rtl/bufout_serializer_if.sv
// Stream bundle of the serializer: triple-parallel input side and
// sample-serial output side.
interface bufout_serializer_if #(
  parameter int DATA_W = fft_buf_pkg::DATA_W
);
  // Both sides use valid/ready: a transfer happens on a rising clock edge where
  // valid and ready are both high; valid must not drop and data must not change
  // while valid is high and ready is low.
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] a_re, b_re, c_re;
  logic [DATA_W-1:0] a_img, b_img, c_img;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_re, out_img;
  logic [1:0]        out_idx;
  logic              out_last;

  // slave: the serializer itself; master: the surrounding producer/consumer.
  modport slave (
    input  in_valid, a_re, b_re, c_re, a_img, b_img, c_img, out_ready,
    output in_ready, out_valid, out_re, out_img, out_idx, out_last
  );

  modport master (
    output in_valid, a_re, b_re, c_re, a_img, b_img, c_img, out_ready,
    input  in_ready, out_valid, out_re, out_img, out_idx, out_last
  );
endinterface

// File: rtl/cplx_triple_reg.sv
// Three complex samples (six DATA_W words) with a common load enable and
// asynchronous active-low clear.
module cplx_triple_reg #(
  parameter int DATA_W = fft_buf_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] d_re  [3],
  input  logic [DATA_W-1:0] d_img [3],
  output logic [DATA_W-1:0] q_re  [3],
  output logic [DATA_W-1:0] q_img [3]
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        q_re[i]  <= '0;
        q_img[i] <= '0;
      end
    end else if (load) begin
      for (int i = 0; i < 3; i++) begin
        q_re[i]  <= d_re[i];
        q_img[i] <= d_img[i];
      end
    end
  end

endmodule

// File: rtl/bufout_serializer.sv
// Serializes one complex triple (a, b, c) per input handshake into three
// samples on a valid/ready stream. Define BUFOUT_SKID_EN for a second (skid)
// triple register and a registered in_ready.
module bufout_serializer
  import fft_buf_pkg::*;
#(
  parameter int DATA_W = fft_buf_pkg::DATA_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  bufout_serializer_if.slave   bus,
  output state_t               dbg_state
);

  state_t            state, state_nxt;
  logic [1:0]        idx, idx_nxt;
  logic              in_xfer, out_xfer, last_xfer, hold_load;
  logic [DATA_W-1:0] in_re [3], in_img [3];
  logic [DATA_W-1:0] hold_d_re [3], hold_d_img [3];
  logic [DATA_W-1:0] hold_re [3], hold_img [3];

  assign in_re[0]  = bus.a_re;
  assign in_re[1]  = bus.b_re;
  assign in_re[2]  = bus.c_re;
  assign in_img[0] = bus.a_img;
  assign in_img[1] = bus.b_img;
  assign in_img[2] = bus.c_img;

  assign out_xfer  = (state == EMIT) && bus.out_ready;
  assign last_xfer = out_xfer && (idx == IDX_C);
  assign in_xfer   = bus.in_valid && bus.in_ready;

`ifdef BUFOUT_SKID_EN
  logic              skid_full, skid_load;
  logic [DATA_W-1:0] skid_re [3], skid_img [3];

  // A triple arriving mid-emission parks in the skid; on the last transfer
  // either the skid or a same-cycle input refills hold (skid full blocks input).
  assign skid_load   = in_xfer && (state == EMIT) && !last_xfer;
  assign hold_load   = (in_xfer && !skid_load) || (last_xfer && skid_full);
  assign bus.in_ready = !skid_full;
  assign hold_d_re   = skid_full ? skid_re  : in_re;
  assign hold_d_img  = skid_full ? skid_img : in_img;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       skid_full <= 1'b0;
    else if (last_xfer && skid_full)  skid_full <= 1'b0;
    else if (skid_load)               skid_full <= 1'b1;
  end

  cplx_triple_reg #(.DATA_W(DATA_W)) u_skid (
    .clk(clk), .rst_n(rst_n), .load(skid_load),
    .d_re(in_re), .d_img(in_img), .q_re(skid_re), .q_img(skid_img)
  );
`else
  assign bus.in_ready = (state == IDLE) ||
                        ((state == EMIT) && (idx == IDX_C) && bus.out_ready);
  assign hold_load    = in_xfer;
  assign hold_d_re    = in_re;
  assign hold_d_img   = in_img;
`endif

  cplx_triple_reg #(.DATA_W(DATA_W)) u_hold (
    .clk(clk), .rst_n(rst_n), .load(hold_load),
    .d_re(hold_d_re), .d_img(hold_d_img), .q_re(hold_re), .q_img(hold_img)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= IDX_A;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    case (state)
      IDLE: begin
        if (in_xfer) begin
          state_nxt = EMIT;
          idx_nxt   = IDX_A;
        end
      end
      EMIT: begin
        if (out_xfer) begin
          if (idx == IDX_C) begin
            idx_nxt   = IDX_A;
            state_nxt = hold_load ? EMIT : IDLE;
          end else begin
            idx_nxt = idx + 2'd1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        idx_nxt   = IDX_A;
      end
    endcase
  end

  // Outputs decode only registered state, so they cannot glitch with inputs.
  always_comb begin
    bus.out_valid = (state == EMIT);
    bus.out_idx   = idx;
    bus.out_last  = (state == EMIT) && (idx == IDX_C);
    bus.out_re    = '0;
    bus.out_img   = '0;
    if (state == EMIT) begin
      case (idx)
        IDX_A:   begin bus.out_re = hold_re[0]; bus.out_img = hold_img[0]; end
        IDX_B:   begin bus.out_re = hold_re[1]; bus.out_img = hold_img[1]; end
        default: begin bus.out_re = hold_re[2]; bus.out_img = hold_img[2]; end
      endcase
    end
  end

  assign dbg_state = state;

endmodule
